// File: rtl/if_stage_if.sv
// ============================================================================
// if_stage_if : instruction-memory request/acknowledge bus (fetch side = master)
// Rev 1.0
// ============================================================================
`default_nettype none

interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : PC, req/ack instruction fetch and IF/ID register (falling-edge state)
// Rev 1.0  | optional macro IF_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  wire logic        CLK,
  input  wire logic        RST_N,
  if_stage_if.master       imem,
  input  wire logic        stall,
  input  wire logic        redirect,
  input  wire logic [31:0] redirect_pc,
  output logic [31:0]      PC_4_IFID,
  output logic [31:0]      instr_IFID,
  output logic             valid_IFID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] hold_instr, hold_next;
  logic [31:0] redir_pc, redir_next;
  logic [31:0] pc4_next, instr_next;
  logic        valid_next;
  logic        fetch_evt, stall_evt;
  logic [31:0] pc_inc;

  assign pc_inc         = pc + PC_STEP;
  assign imem.imem_addr = pc;
  assign imem.imem_req  = RST_N && ((state == ST_FETCH) || (state == ST_DRAIN));

  always_comb begin
    state_next = state;
    pc_next    = pc;
    hold_next  = hold_instr;
    redir_next = redir_pc;
    pc4_next   = PC_4_IFID;
    instr_next = instr_IFID;
    valid_next = valid_IFID;
    fetch_evt  = 1'b0;
    stall_evt  = 1'b0;

    case (state)
      ST_FETCH: begin
        stall_evt = !imem.imem_ack;
        if (redirect && imem.imem_ack) begin
          pc_next    = redirect_pc;
          valid_next = 1'b0;
        end else if (redirect) begin
          // Keep pc so the outstanding address stays stable until the ack.
          redir_next = redirect_pc;
          valid_next = 1'b0;
          state_next = ST_DRAIN;
        end else if (imem.imem_ack && !stall) begin
          pc4_next   = pc_inc;
          instr_next = imem.imem_rdata;
          valid_next = 1'b1;
          pc_next    = pc_inc;
          fetch_evt  = 1'b1;
        end else if (imem.imem_ack) begin
          hold_next  = imem.imem_rdata;
          state_next = ST_HOLD;
        end else if (!stall) begin
          valid_next = 1'b0;
        end
      end

      ST_HOLD: begin
        stall_evt = 1'b1;
        if (redirect) begin
          pc_next    = redirect_pc;
          valid_next = 1'b0;
          state_next = ST_FETCH;
        end else if (!stall) begin
          pc4_next   = pc_inc;
          instr_next = hold_instr;
          valid_next = 1'b1;
          pc_next    = pc_inc;
          fetch_evt  = 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        valid_next = 1'b0;
        if (redirect) redir_next = redirect_pc;
        if (imem.imem_ack) begin
          pc_next    = redirect ? redirect_pc : redir_pc;
          state_next = ST_FETCH;
        end
      end

      default: begin
        state_next = ST_FETCH;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      hold_instr <= 32'h0;
      redir_pc   <= 32'h0;
      PC_4_IFID  <= 32'h0;
      instr_IFID <= 32'h0;
      valid_IFID <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      hold_instr <= hold_next;
      redir_pc   <= redir_next;
      PC_4_IFID  <= pc4_next;
      instr_IFID <= instr_next;
      valid_IFID <= valid_next;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (fetch_evt) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed vector table, multi-cycle sequences and random run
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        CLK;
  logic        RST_N;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] PC_4_IFID;
  logic [31:0] instr_IFID;
  logic        valid_IFID;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  if_stage_if bus ();

  if_stage #(.RESET_PC(TB_RESET_PC), .PC_STEP(32'd4)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .PC_4_IFID   (PC_4_IFID),
    .instr_IFID  (instr_IFID),
    .valid_IFID  (valid_IFID)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch unit owes ID, described as "is a word
  // parked waiting for stall to drop" and "is a wrong-path fetch in flight".
  logic [31:0] m_pc, m_pc4, m_instr, m_held, m_target, m_fcnt, m_scnt;
  logic        m_valid, m_holding, m_wrong;

  task automatic model_reset();
    m_pc = TB_RESET_PC; m_pc4 = 0; m_instr = 0; m_valid = 0;
    m_holding = 0; m_held = 0; m_wrong = 0; m_target = 0;
    m_fcnt = 0; m_scnt = 0;
  endtask

  task automatic model_deliver(input logic [31:0] w);
    m_pc    = m_pc + 32'd4;
    m_pc4   = m_pc;
    m_instr = w;
    m_valid = 1'b1;
    m_fcnt  = m_fcnt + 1;
  endtask

  task automatic model_step(input logic a, s, r, input logic [31:0] rp, rd);
    if (m_wrong) begin
      m_valid = 1'b0;
      if (r) m_target = rp;
      if (a) begin m_pc = m_target; m_wrong = 1'b0; end
    end else if (m_holding) begin
      m_scnt = m_scnt + 1;
      if (r) begin m_holding = 1'b0; m_pc = rp; m_valid = 1'b0; end
      else if (!s) begin m_holding = 1'b0; model_deliver(m_held); end
    end else begin
      if (!a) m_scnt = m_scnt + 1;
      if (r) begin
        m_valid = 1'b0;
        if (a) m_pc = rp;
        else begin m_wrong = 1'b1; m_target = rp; end
      end else if (a && s) begin
        m_holding = 1'b1; m_held = rd;
      end else if (a) begin
        model_deliver(rd);
      end else if (!s) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req),   32'(!m_holding));
    chk({tag, "_addr"},  bus.imem_addr,       m_pc);
    chk({tag, "_pc4"},   PC_4_IFID,           m_pc4);
    chk({tag, "_instr"}, instr_IFID,          m_instr);
    chk({tag, "_valid"}, 32'(valid_IFID),     32'(m_valid));
`ifdef IF_PERF_CNT_EN
    chk({tag, "_fcnt"},  fetch_cnt,           m_fcnt);
    chk({tag, "_scnt"},  stall_cnt,           m_scnt);
`endif
  endtask

  // Inputs are applied just after a falling edge and sampled on the next one.
  task automatic step(input string tag, input logic a, s, r, input logic [31:0] rp, rd);
    bus.imem_ack   = a;
    bus.imem_rdata = rd;
    stall          = s;
    redirect       = r;
    redirect_pc    = rp;
    model_step(a, s, r, rp, rd);
    @(negedge CLK);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic        ack, stl, rdr;
    logic [31:0] rpc, rdata;
    logic        req;
    logic [31:0] addr, pc4, instr;
    logic        valid;
  } vec_t;

  vec_t tbl [23];

  initial begin
    logic [31:0] prev_addr;
    logic        a, s, r;

    tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,32'hA5A5_0000, 1'b1,32'h4,32'h4,32'hA5A5_0000,1'b1};
    tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,32'hA5A5_0004, 1'b1,32'h8,32'h8,32'hA5A5_0004,1'b1};
    tbl[2]  = '{1'b1,1'b1,1'b0,32'h0,32'hA5A5_0008, 1'b0,32'h8,32'h8,32'hA5A5_0004,1'b1};
    tbl[3]  = '{1'b0,1'b1,1'b0,32'h0,32'h0,         1'b0,32'h8,32'h8,32'hA5A5_0004,1'b1};
    tbl[4]  = '{1'b0,1'b1,1'b0,32'h0,32'h0,         1'b0,32'h8,32'h8,32'hA5A5_0004,1'b1};
    tbl[5]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,32'hC,32'hC,32'hA5A5_0008,1'b1};
    tbl[6]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,32'hC,32'hC,32'hA5A5_0008,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,32'hC,32'hC,32'hA5A5_0008,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,32'h0,32'hA5A5_000C, 1'b1,32'h10,32'h10,32'hA5A5_000C,1'b1};
    tbl[9]  = '{1'b0,1'b0,1'b1,32'h100,32'h0,       1'b1,32'h10,32'h10,32'hA5A5_000C,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b1,32'h200,32'h0,       1'b1,32'h10,32'h10,32'hA5A5_000C,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,32'h0,32'hA5A5_0010, 1'b1,32'h200,32'h10,32'hA5A5_000C,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,32'h0,32'hA5A5_0200, 1'b1,32'h204,32'h204,32'hA5A5_0200,1'b1};
    tbl[13] = '{1'b1,1'b0,1'b1,32'h300,32'hA5A5_0204,1'b1,32'h300,32'h204,32'hA5A5_0200,1'b0};
    tbl[14] = '{1'b1,1'b0,1'b0,32'h0,32'hA5A5_0300, 1'b1,32'h304,32'h304,32'hA5A5_0300,1'b1};
    tbl[15] = '{1'b1,1'b1,1'b1,32'h400,32'hA5A5_0304,1'b1,32'h400,32'h304,32'hA5A5_0300,1'b0};
    tbl[16] = '{1'b1,1'b0,1'b0,32'h0,32'hA5A5_0400, 1'b1,32'h404,32'h404,32'hA5A5_0400,1'b1};
    tbl[17] = '{1'b1,1'b1,1'b0,32'h0,32'hDEAD_BEEF, 1'b0,32'h404,32'h404,32'hA5A5_0400,1'b1};
    tbl[18] = '{1'b0,1'b1,1'b1,32'h500,32'h0,       1'b1,32'h500,32'h404,32'hA5A5_0400,1'b0};
    tbl[19] = '{1'b0,1'b0,1'b1,32'h600,32'h0,       1'b1,32'h500,32'h404,32'hA5A5_0400,1'b0};
    tbl[20] = '{1'b1,1'b0,1'b1,32'h700,32'h0000_0BAD,1'b1,32'h700,32'h404,32'hA5A5_0400,1'b0};
    tbl[21] = '{1'b1,1'b0,1'b1,32'hFFFF_FFFC,32'hA5A5_0700,1'b1,32'hFFFF_FFFC,32'h404,32'hA5A5_0400,1'b0};
    tbl[22] = '{1'b1,1'b0,1'b0,32'h0,32'h5A5A_FFFC, 1'b1,32'h0,32'h0,32'h5A5A_FFFC,1'b1};

    RST_N = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    model_reset();
    #3;
    chk("rst_req",   32'(bus.imem_req), 32'h0);
    chk("rst_addr",  bus.imem_addr,     TB_RESET_PC);
    chk("rst_pc4",   PC_4_IFID,         32'h0);
    chk("rst_instr", instr_IFID,        32'h0);
    chk("rst_valid", 32'(valid_IFID),   32'h0);
    #9 RST_N = 1'b1;
    #1;
    chk("post_rst_req", 32'(bus.imem_req), 32'h1);

    foreach (tbl[i]) begin
      step($sformatf("v%0d_model", i), tbl[i].ack, tbl[i].stl, tbl[i].rdr, tbl[i].rpc, tbl[i].rdata);
      chk($sformatf("v%0d_req", i),   32'(bus.imem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),  bus.imem_addr,     tbl[i].addr);
      chk($sformatf("v%0d_pc4", i),   PC_4_IFID,         tbl[i].pc4);
      chk($sformatf("v%0d_instr", i), instr_IFID,        tbl[i].instr);
      chk($sformatf("v%0d_valid", i), 32'(valid_IFID),   32'(tbl[i].valid));
    end

    // Slow memory: ack on every third edge.
    for (int i = 0; i < 9; i++) begin
      a = (i % 3 == 2);
      prev_addr = bus.imem_addr;
      step("lat_model", a, 1'b0, 1'b0, 32'h0, bus.imem_addr ^ 32'hA5A5_0000);
      chk("lat_valid", 32'(valid_IFID), 32'(a));
      if (!a) chk("lat_addr_stable", bus.imem_addr, prev_addr);
    end

    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 99) < 60);
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 8);
      step("rnd", a, s, r, $urandom & 32'hFFFF_FFFC, $urandom);
    end

    // Asynchronous reset while a wrong-path fetch is in flight.
    step("drain_entry_setup", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    step("drain_entry", 1'b0, 1'b0, 1'b1, 32'h800, 32'h0);
    chk("drain_valid", 32'(valid_IFID), 32'h0);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_req",   32'(bus.imem_req), 32'h0);
    chk("arst_addr",  bus.imem_addr,     TB_RESET_PC);
    chk("arst_pc4",   PC_4_IFID,         32'h0);
    chk("arst_instr", instr_IFID,        32'h0);
    chk("arst_valid", 32'(valid_IFID),   32'h0);
`ifdef IF_PERF_CNT_EN
    chk("arst_fcnt",  fetch_cnt,         32'h0);
    chk("arst_scnt",  stall_cnt,         32'h0);
`endif
    model_reset();
    #2 RST_N = 1'b1;
    #1;
    chk("rel_addr", bus.imem_addr,     TB_RESET_PC);
    chk("rel_req",  32'(bus.imem_req), 32'h1);
    step("rel_fetch0", 1'b1, 1'b0, 1'b0, 32'h0, 32'hCAFE_0000);
    step("rel_fetch1", 1'b1, 1'b0, 1'b0, 32'h0, 32'hCAFE_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
